lcd_1602_reader: RTL and testbench

// Read-side controller for the HD44780-compatible 1602 character LCD bus.

---
 rtl/lcd_1602_reader.sv | 169 ++++++++++++++++
 tb/tb_lcd_1602_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_1602_reader.sv
// lcd_1602_reader
// Read-side controller for an HD44780-compatible 1602 LCD bus. Each request
// runs one RW=1 transfer: a busy-flag/address read (RS=0) or a data read
// (RS=1). In poll mode it repeats BF reads until BF=0, or it gives up after
// POLL_MAX reads. The block shares the bus with a write-side driver.
// LCD_DATA_OE=1 gives the bus to the write side. This block drops OE to 0
// before it raises RW.
//
// Ports
//   clock, reset            50 MHz clock, synchronous active-low reset
//   req/req_rs/req_poll     request strobe, register select, BF poll mode
//   ready                   idle, a req on this edge is accepted
//   rd_valid                one-cycle pulse: rd_data (and bf/ac for RS=0) updated
//   rd_data, bf, ac         last raw byte, busy flag, address counter
//   timeout                 one-cycle pulse: poll exhausted with BF still set
//   LCD_DATA_IN             LCD data bus input
//   LCD_RS/RW/EN            LCD control strobes
//   LCD_DATA_OE             1 = write side may drive the bus
module lcd_1602_reader #(
    parameter int T_AS     = 2,
    parameter int T_PW     = 12,
    parameter int T_H      = 2,
    parameter int T_REC    = 12,
    parameter int POLL_MAX = 4095
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       bf,
    output logic [6:0] ac,
    output logic       timeout,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_DATA_OE
);

    localparam int PCW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TURN, S_SETUP, S_EN_HI, S_HOLD, S_RECOVER
    } state_t;

    state_t         state;
    logic [15:0]    cnt;        // cycles left in the current phase, minus one
    logic           rs_q;
    logic           poll_q;
    logic           again_q;    // poll saw BF=1: loop back to SETUP after recovery
    logic [PCW-1:0] reads;      // EN pulses issued for this request
    logic [7:0]     capture;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_RECOVER;
            cnt         <= 16'(T_REC - 1);
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            again_q     <= 1'b0;
            reads       <= '0;
            capture     <= 8'h00;
            ready       <= 1'b0;
            rd_valid    <= 1'b0;
            timeout     <= 1'b0;
            rd_data     <= 8'h00;
            bf          <= 1'b0;
            ac          <= 7'h00;
            LCD_RS      <= 1'b0;
            LCD_RW      <= 1'b0;
            LCD_EN      <= 1'b0;
            LCD_DATA_OE <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        rs_q        <= req_rs;
                        poll_q      <= req_poll & ~req_rs;
                        reads       <= '0;
                        again_q     <= 1'b0;
                        ready       <= 1'b0;
                        LCD_DATA_OE <= 1'b0;   // release the bus a cycle before RW rises
                        state       <= S_TURN;
                    end
                end
                S_TURN: begin
                    state  <= S_SETUP;
                    cnt    <= 16'(T_AS - 1);
                    LCD_RW <= 1'b1;
                    LCD_RS <= rs_q;
                end
                S_SETUP: begin
                    if (cnt == 16'd0) begin
                        state  <= S_EN_HI;
                        cnt    <= 16'(T_PW - 1);
                        LCD_EN <= 1'b1;
                        reads  <= reads + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EN_HI: begin
                    if (cnt == 16'd0) begin
                        // last EN-high cycle: data has had the full pulse width to settle
                        capture <= LCD_DATA_IN;
                        state   <= S_HOLD;
                        cnt     <= 16'(T_H - 1);
                        LCD_EN  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 16'd0) begin
                        state   <= S_RECOVER;
                        cnt     <= 16'(T_REC - 1);
                        LCD_RW  <= 1'b0;
                        LCD_RS  <= 1'b0;
                        rd_data <= capture;
                        if (!rs_q) begin
                            bf <= capture[7];
                            ac <= capture[6:0];
                        end
                        if (poll_q && capture[7]) begin
                            if (reads == PCW'(POLL_MAX)) timeout <= 1'b1;
                            else                         again_q <= 1'b1;
                        end else begin
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (cnt == 16'd0) begin
                        again_q <= 1'b0;
                        if (again_q) begin
                            // OE is still low from the first read, so TURN is skipped
                            state  <= S_SETUP;
                            cnt    <= 16'(T_AS - 1);
                            LCD_RW <= 1'b1;
                            LCD_RS <= rs_q;
                        end else begin
                            state       <= S_IDLE;
                            ready       <= 1'b1;
                            LCD_DATA_OE <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_RECOVER;
                    cnt    <= 16'(T_REC - 1);
                    LCD_RW <= 1'b0;
                    LCD_RS <= 1'b0;
                    LCD_EN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_1602_reader.sv
// Bench for lcd_1602_reader. An LCD bus model hands out one queued byte per
// EN pulse. A per-request reference model predicts the transfer outcome from
// the queued bytes and the timing parameters. A monitor checks the bus
// ownership rules and the EN pulse width on every cycle.
module tb_lcd_1602_reader;

    localparam int T_AS = 2, T_PW = 12, T_H = 2, T_REC = 12, POLL_MAX = 4;
    localparam int FIRST_LAT = 1 + T_AS + T_PW + T_H;
    localparam int LOOP_LAT  = T_AS + T_PW + T_H + T_REC;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0, req_rs = 1'b0, req_poll = 1'b0;
    logic       ready, rd_valid, bf, timeout;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic [7:0] LCD_DATA_IN = 8'h00;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_DATA_OE;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int en_pulses = 0;
    int en_run = 0;
    bit abort_en = 0;
    logic prev_oe = 1'b0, prev_rw = 1'b0, prev_en = 1'b0;
    logic [7:0] bus_q[$];
    logic       exp_bf = 1'b0;
    logic [6:0] exp_ac = 7'h00;

    lcd_1602_reader #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_REC(T_REC), .POLL_MAX(POLL_MAX)) dut (
        .clock(clock), .reset(reset), .req(req), .req_rs(req_rs), .req_poll(req_poll),
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .bf(bf), .ac(ac),
        .timeout(timeout), .LCD_DATA_IN(LCD_DATA_IN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_DATA_OE(LCD_DATA_OE)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // LCD side: each EN pulse presents the next queued byte
    always @(posedge LCD_EN) begin
        en_pulses++;
        if (bus_q.size() > 0) LCD_DATA_IN = bus_q.pop_front();
        else                  LCD_DATA_IN = 8'($urandom);
    end

    // bus ownership and strobe rules
    always @(negedge clock) begin
        chk("rw_while_oe", 32'(LCD_RW & LCD_DATA_OE), 0);
        chk("valid_and_timeout", 32'(rd_valid & timeout), 0);
        chk("oe_rise_while_busy",
            32'(LCD_DATA_OE & ~prev_oe & (prev_rw | prev_en | LCD_RW | LCD_EN)), 0);
        if (LCD_EN) en_run++;
        else if (en_run != 0) begin
            if (!abort_en) chk("en_width", en_run, T_PW);
            abort_en = 0;
            en_run   = 0;
        end
        prev_oe = LCD_DATA_OE; prev_rw = LCD_RW; prev_en = LCD_EN;
    end

    // Runs one request against the bytes in bus_q and checks the outcome
    // against what the read rules predict.
    task automatic do_req(input logic rs, input logic poll, input string tag);
        int pulses, w, t0, t_ev;
        bit to_exp;
        logic [7:0] v;
        pulses = 1; to_exp = 0; v = bus_q[0];
        if (!rs && poll) begin
            pulses = POLL_MAX; to_exp = 1;
            for (int i = 0; i < POLL_MAX; i++)
                if (!bus_q[i][7]) begin pulses = i + 1; to_exp = 0; break; end
            v = bus_q[pulses-1];
        end
        if (!rs) begin exp_bf = v[7]; exp_ac = v[6:0]; end

        w = 0;
        while (!ready && w < 100) begin @(negedge clock); w++; end
        chk({tag, " ready_before"}, 32'(ready), 1);
        en_pulses = 0;
        req = 1'b1; req_rs = rs; req_poll = poll;
        @(negedge clock);
        t0 = cyc;
        w = 0;
        while (!(rd_valid || timeout) && w < 400) begin
            req = (w == 4);          // a request while busy must be dropped
            @(negedge clock);
            w++;
        end
        req = 1'b0;
        t_ev = cyc;
        chk({tag, " latency"}, t_ev - t0, FIRST_LAT + LOOP_LAT * (pulses - 1));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(!to_exp));
        chk({tag, " timeout"}, 32'(timeout), 32'(to_exp));
        chk({tag, " rd_data"}, 32'(rd_data), 32'(v));
        chk({tag, " bf"}, 32'(bf), 32'(exp_bf));
        chk({tag, " ac"}, 32'(ac), 32'(exp_ac));
        chk({tag, " en_pulses"}, en_pulses, pulses);
        @(negedge clock);
        chk({tag, " pulse_len"}, 32'(rd_valid | timeout), 0);
        w = 0;
        while (!ready && w < 60) begin @(negedge clock); w++; end
        chk({tag, " ready_after"}, cyc - t_ev, T_REC);
        @(negedge clock);
        chk({tag, " no_queued_req"}, 32'({ready, LCD_DATA_OE, 6'(en_pulses)}),
            32'({1'b1, 1'b1, 6'(pulses)}));
        bus_q.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, nv;
        logic [7:0] b;
        int k;
        // 1: reset
        repeat (5) @(negedge clock);
        reset = 1'b1;
        chk("rst rd_data", 32'(rd_data), 0);
        chk("rst bf_ac", 32'({bf, ac}), 0);
        chk("rst pulses", 32'({rd_valid, timeout}), 0);
        for (int i = 0; i < T_REC; i++) begin
            chk("rst quiet", 32'({ready, LCD_EN, LCD_RW, LCD_DATA_OE}), 0);
            @(negedge clock);
        end
        chk("rst ready", 32'({ready, LCD_DATA_OE}), 32'(2'b11));

        // 2-5: directed reads
        bus_q.push_back(8'h25);                 do_req(1'b0, 1'b0, "bfac");
        bus_q.push_back(8'h41);                 do_req(1'b1, 1'b0, "data");
        bus_q = '{8'hA3, 8'hA3, 8'hA3, 8'h03};  do_req(1'b0, 1'b1, "poll");
        bus_q = '{8'h80, 8'h80, 8'h80, 8'h80};  do_req(1'b0, 1'b1, "poll_to");
        bus_q = '{8'h11, 8'h80, 8'h80, 8'h80};  do_req(1'b0, 1'b1, "poll_now");

        // randomized requests
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 5);
            for (int i = 0; i < POLL_MAX + 2; i++) begin
                b = 8'($urandom);
                b[7] = (i < k);
                bus_q.push_back(b);
            end
            do_req(1'($urandom), 1'($urandom), "rand");
        end

        // 6: reset during EN high, with a busy request in between
        bus_q.push_back(8'h55);
        w = 0;
        while (!ready && w < 100) begin @(negedge clock); w++; end
        req = 1'b1; req_rs = 1'b0; req_poll = 1'b0;
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        w = 0;
        while (!LCD_EN && w < 50) begin @(negedge clock); w++; end
        chk("abort en_reached", 32'(LCD_EN), 1);
        @(negedge clock);
        abort_en = 1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort strobes", 32'({LCD_EN, LCD_RW, LCD_DATA_OE, ready, rd_valid}), 0);
        chk("abort regs", 32'({rd_data, bf, ac}), 0);
        reset = 1'b1;
        en_pulses = 0;
        nv = 0;
        repeat (40) begin @(negedge clock); if (rd_valid || timeout) nv++; end
        chk("abort no_valid", nv, 0);
        chk("abort no_restart", en_pulses, 0);
        chk("abort ready", 32'(ready), 1);
        bus_q.delete();
        exp_bf = 1'b0; exp_ac = 7'h00;

        bus_q.push_back(8'h7F);                 do_req(1'b0, 1'b0, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
